dir_seq_n: RTL and testbench
============================

DIR_SEQ_N -- requirements
Module: dir_seq_n

Interface
- REQ-001: Parameter N_IR, default 3, number of IR position sensors (2..8).
- REQ-002: Parameter SYNC_STAGES, default 2, synchronizer flops per async input (2..3).
- REQ-003: Parameter TIMEOUT, default 1000000, max cycles between accepted sensor edges; 0 disables the timeout.
- REQ-004: Parameter DWELL, default 1000, cycles the motor stays stopped in END before reversing (>=1).
- REQ-005: Port CLK, input, 1, the design's single clock; all logic on rising edge.
- REQ-006: Port RSTn, input, 1, asynchronous active-low reset.
- REQ-007: Port IR, input, N_IR, asynchronous sensor levels; 1 = clear, 0 = blocked.
- REQ-008: Port SW, input, 1, asynchronous start/clear button; only its synchronized rising edge acts.
- REQ-009: Port dir, output, 1, motor direction; 1 = FW, 0 = BW.
- REQ-010: Port en, output, 1, motor enable.
- REQ-011: Port state, output, 3, current state encoding per REQ-015.
- REQ-012: Port idx, output, $clog2(N_IR), index of the next expected sensor.
- REQ-013: Port fault, output, 1, high while in FAULT.
- REQ-014: Port done, output, 1, one-cycle pulse on completion of a full FW+BW run.

Function
- REQ-015: States SHALL be HOME=0, FW_FALL=1, FW_RISE=2, END=3, BW_FALL=4, BW_RISE=5, FAULT=6; code 7 unreachable and SHALL recover to FAULT.
- REQ-016: IR and SW SHALL each pass through SYNC_STAGES flops plus one previous-value flop; rise = sync & ~prev, fall = ~sync & prev.
- REQ-017: Latency from an IR/SW input change to the resulting state change SHALL be SYNC_STAGES+1 cycles.
- REQ-018: HOME: en=0, dir=1; SW rise -> FW_FALL, idx=0, en=1.
- REQ-019: FW_FALL expects fall on IR[idx]; on it, idx+1, or if idx=N_IR-1 -> FW_RISE, idx=0.
- REQ-020: FW_RISE expects rise on IR[idx]; on it, idx+1, or if idx=N_IR-1 -> END, en=0.
- REQ-021: END SHALL hold en=0 for DWELL cycles, then -> BW_FALL, dir=0, en=1, idx=N_IR-1.
- REQ-022: BW_FALL expects fall on IR[idx]; on it, idx-1, or if idx=0 -> BW_RISE, idx=N_IR-1.
- REQ-023: BW_RISE expects rise on IR[idx]; on it, idx-1, or if idx=0 -> HOME, en=0, dir=1, done=1 for one cycle.
- REQ-024: In FW_*/BW_* states, any edge other than the expected one (wrong sensor or wrong polarity) SHALL go to FAULT, en=0.
- REQ-025: Expected and unexpected edges in the same cycle SHALL go to FAULT (fault wins).
- REQ-026: Timeout counter SHALL clear on state entry and on every accepted edge, count in FW_*/BW_* states, and at TIMEOUT go to FAULT; saturates, no wrap.
- REQ-027: IR edges SHALL be ignored in HOME, END and FAULT; SW rise SHALL be ignored in every state except HOME and FAULT.
- REQ-028: FAULT: en=0, fault=1, dir held; SW rise -> HOME (dir=1, idx=0, counters cleared).
- REQ-029: Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
- REQ-030: On RSTn=0, asynchronously: state=HOME, dir=1, en=0, fault=0, done=0, idx=0, counters 0.
- REQ-031: IR sync/prev flops SHALL reset to all ones and SW flops to zero, so no edge is seen after reset release.
- REQ-032: Reset mid-run SHALL abort immediately with the REQ-030 values; no run resumes after release.

Verification (N_IR=3, SYNC_STAGES=2, TIMEOUT=100, DWELL=4)
- REQ-033: Full run: SW pulse, IR falls 0,1,2, rises 0,1,2, then after dwell falls 2,1,0, rises 2,1,0 -> states 1,2,3,4,5,0; dir 1->0 after 4 stopped cycles; done pulses once; en=0 at end.
- REQ-034: Out of order: in FW_FALL idx=0, fall on IR[1] -> state=6, fault=1, en=0 three cycles later; SW pulse -> state=0, fault=0.
- REQ-035: Timeout: SW pulse, no IR activity -> FAULT exactly 100 cycles after FW_FALL entry.
- REQ-036: Simultaneous: in FW_FALL idx=0, IR[0] and IR[2] fall on the same edge -> FAULT, idx stays 0.
- REQ-037: Reset: RSTn low during BW_FALL -> same cycle dir=1, en=0, state=0; glitch-free after release with IR=3'b111.
- REQ-038: Ignored inputs: IR toggles in HOME and SW pulse during FW_RISE -> no state change.

Source files
------------

// File: rtl/dir_seq_n.sv
// Motor direction sequencer: runs forward then backward across N_IR IR position
// sensors, checking the order of sensor edges, with timeout, end dwell and fault recovery.
module dir_seq_n #(
    parameter int N_IR        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000000,
    parameter int DWELL       = 1000
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic [N_IR-1:0]         IR,
    input  logic                    SW,
    output logic                    dir,
    output logic                    en,
    output logic [2:0]              state,
    output logic [$clog2(N_IR)-1:0] idx,
    output logic                    fault,
    output logic                    done
);

    localparam int IDX_W   = $clog2(N_IR);
    localparam int CNT_MAX = (TIMEOUT > DWELL) ? TIMEOUT : DWELL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IR - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DWELL - 1);

    typedef enum logic [2:0] {
        ST_HOME    = 3'd0,
        ST_FW_FALL = 3'd1,
        ST_FW_RISE = 3'd2,
        ST_END     = 3'd3,
        ST_BW_FALL = 3'd4,
        ST_BW_RISE = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0][N_IR-1:0] r_ir_sync;
    logic [N_IR-1:0]                  r_ir_prev;
    logic [SYNC_STAGES-1:0]           r_sw_sync;
    logic                             r_sw_prev;

    // NOTE: IR idles high (clear) and SW idles low, so these reset values make
    // the first cycles after reset release edge-free.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ir_sync <= '1;
            r_ir_prev <= '1;
            r_sw_sync <= '0;
            r_sw_prev <= 1'b0;
        end else begin
            r_ir_sync <= {r_ir_sync[SYNC_STAGES-2:0], IR};
            r_ir_prev <= r_ir_sync[SYNC_STAGES-1];
            r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], SW};
            r_sw_prev <= r_sw_sync[SYNC_STAGES-1];
        end
    end

    logic [N_IR-1:0] w_ir_now;
    logic [N_IR-1:0] w_ir_fall;
    logic [N_IR-1:0] w_ir_rise;
    logic [N_IR-1:0] w_ir_edge;
    logic [N_IR-1:0] w_sel_mask;
    logic [N_IR-1:0] w_exp_vec;
    logic            w_sw_rise;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_en;
    logic             r_fault;
    logic             r_done;

    logic w_fall_phase;
    logic w_fw;
    logic w_hit;
    logic w_bad;
    logic w_last;
    logic w_timeout;

    assign w_ir_now   = r_ir_sync[SYNC_STAGES-1];
    assign w_ir_fall  = ~w_ir_now & r_ir_prev;
    assign w_ir_rise  = w_ir_now & ~r_ir_prev;
    assign w_ir_edge  = w_ir_fall | w_ir_rise;
    assign w_sw_rise  = r_sw_sync[SYNC_STAGES-1] & ~r_sw_prev;
    assign w_sel_mask = N_IR'(1) << r_idx;

    assign w_fall_phase = (r_state == ST_FW_FALL) || (r_state == ST_BW_FALL);
    assign w_fw         = (r_state == ST_FW_FALL) || (r_state == ST_FW_RISE);
    assign w_exp_vec    = w_fall_phase ? w_ir_fall : w_ir_rise;
    assign w_hit        = |(w_exp_vec & w_sel_mask);
    // Any edge besides the single expected one is a fault, even alongside a hit.
    assign w_bad        = |(w_ir_edge & ~(w_exp_vec & w_sel_mask));
    assign w_last       = w_fw ? (r_idx == IDX_LAST) : (r_idx == '0);
    assign w_timeout    = (TIMEOUT != 0) && (r_cnt >= TO_LAST);

    state_t           w_state_nx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_dir_nx;
    logic             w_en_nx;
    logic             w_fault_nx;
    logic             w_done_nx;

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_dir_nx   = r_dir;
        w_done_nx  = 1'b0;

        case (r_state)
            ST_HOME: begin
                if (w_sw_rise) begin
                    w_state_nx = ST_FW_FALL;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                    w_dir_nx   = 1'b1;
                end
            end
            ST_FW_FALL, ST_FW_RISE, ST_BW_FALL, ST_BW_RISE: begin
                w_cnt_nx = '0;
                if (w_bad || (!w_hit && w_timeout)) begin
                    w_state_nx = ST_FAULT;
                end else if (w_hit) begin
                    if (!w_last) begin
                        w_idx_nx = w_fw ? r_idx + 1'b1 : r_idx - 1'b1;
                    end else begin
                        case (r_state)
                            ST_FW_FALL: begin
                                w_state_nx = ST_FW_RISE;
                                w_idx_nx   = '0;
                            end
                            ST_FW_RISE: w_state_nx = ST_END;
                            ST_BW_FALL: begin
                                w_state_nx = ST_BW_RISE;
                                w_idx_nx   = IDX_LAST;
                            end
                            default: begin
                                w_state_nx = ST_HOME;
                                w_idx_nx   = '0;
                                w_dir_nx   = 1'b1;
                                w_done_nx  = 1'b1;
                            end
                        endcase
                    end
                end else if (r_cnt < TO_LAST) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_END: begin
                if (r_cnt >= DW_LAST) begin
                    w_state_nx = ST_BW_FALL;
                    w_idx_nx   = IDX_LAST;
                    w_cnt_nx   = '0;
                    w_dir_nx   = 1'b0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_FAULT: begin
                if (w_sw_rise) begin
                    w_state_nx = ST_HOME;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                    w_dir_nx   = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_FAULT;
                w_cnt_nx   = '0;
            end
        endcase

        w_en_nx    = (w_state_nx == ST_FW_FALL) || (w_state_nx == ST_FW_RISE) ||
                     (w_state_nx == ST_BW_FALL) || (w_state_nx == ST_BW_RISE);
        w_fault_nx = (w_state_nx == ST_FAULT);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_HOME;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b1;
            r_en    <= 1'b0;
            r_fault <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_dir   <= w_dir_nx;
            r_en    <= w_en_nx;
            r_fault <= w_fault_nx;
            r_done  <= w_done_nx;
        end
    end

    assign state = r_state;
    assign idx   = r_idx;
    assign dir   = r_dir;
    assign en    = r_en;
    assign fault = r_fault;
    assign done  = r_done;

endmodule

// File: tb/tb_dir_seq_n.sv
// Bench for dir_seq_n: table-driven full run, hand-written corner sequences, and
// randomized stimulus against a run-position reference model.
module tb_dir_seq_n;

    localparam int N  = 3;
    localparam int S  = 2;
    localparam int TO = 100;
    localparam int DW = 4;
    localparam int IW = $clog2(N);

    logic          CLK  = 1'b0;
    logic          RSTn = 1'b0;
    logic          SW   = 1'b0;
    logic [N-1:0]  IR   = '1;
    logic          dir, en, fault, done;
    logic [2:0]    state;
    logic [IW-1:0] idx;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dir_seq_n #(.N_IR(N), .SYNC_STAGES(S), .TIMEOUT(TO), .DWELL(DW)) dut (
        .CLK(CLK), .RSTn(RSTn), .IR(IR), .SW(SW),
        .dir(dir), .en(en), .state(state), .idx(idx), .fault(fault), .done(done)
    );

    function automatic logic [31:0] pack(input int st, input int ix, input logic e, input logic d,
                                         input logic f, input logic dn);
        logic [2:0]    stw;
        logic [IW-1:0] ixw;
        stw = 3'(st);
        ixw = IW'(ix);
        return 32'({stw, ixw, e, d, f, dn});
    endfunction

    function automatic logic [31:0] actual();
        return pack(int'(state), int'(idx), en, dir, fault, done);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {st,idx,en,dir,fault,done}=%h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the run is a list of 4*N expected sensor events, tracked by position k.
    typedef enum {M_HOME, M_RUN, M_END, M_FAULT} mmode_t;
    mmode_t       m_mode;
    int           m_k, m_cnt, m_fidx;
    bit           m_dir, m_done;
    logic [N-1:0] m_ir_q[$];
    logic         m_sw_q[$];

    function automatic int sensor(input int k);
        int ph = k / N;
        int pos = k % N;
        return (ph < 2) ? pos : N - 1 - pos;
    endfunction

    function automatic void model_reset();
        m_mode = M_HOME; m_k = 0; m_cnt = 0; m_fidx = 0; m_dir = 1'b1; m_done = 1'b0;
        m_ir_q.delete();
        m_sw_q.delete();
        for (int i = 0; i < S + 1; i++) begin
            m_ir_q.push_front('1);
            m_sw_q.push_front(1'b0);
        end
    endfunction

    function automatic void model_step(input logic [N-1:0] ir, input logic sw);
        logic [N-1:0] cur, old, fl, rs, other;
        logic swr;
        int sn;
        bit hit;
        m_ir_q.push_front(ir);
        m_sw_q.push_front(sw);
        cur = m_ir_q[S];
        old = m_ir_q[S+1];
        swr = m_sw_q[S] & ~m_sw_q[S+1];
        void'(m_ir_q.pop_back());
        void'(m_sw_q.pop_back());
        fl = ~cur & old;
        rs = cur & ~old;
        m_done = 1'b0;
        case (m_mode)
            M_HOME: if (swr) begin m_mode = M_RUN; m_k = 0; m_cnt = 0; m_dir = 1'b1; end
            M_FAULT: if (swr) begin m_mode = M_HOME; m_cnt = 0; m_dir = 1'b1; end
            M_END: begin
                if (m_cnt >= DW - 1) begin m_mode = M_RUN; m_k = 2 * N; m_cnt = 0; m_dir = 1'b0; end
                else m_cnt++;
            end
            default: begin
                sn = sensor(m_k);
                hit = ((m_k / N) % 2 == 0) ? fl[sn] : rs[sn];
                other = fl | rs;
                if (hit) other[sn] = 1'b0;
                if (other != '0) begin
                    m_mode = M_FAULT; m_fidx = sn;
                end else if (hit) begin
                    m_k++;
                    m_cnt = 0;
                    if (m_k == 2 * N) m_mode = M_END;
                    else if (m_k == 4 * N) begin m_mode = M_HOME; m_k = 0; m_dir = 1'b1; m_done = 1'b1; end
                end else if (m_cnt + 1 >= TO) begin
                    m_mode = M_FAULT; m_fidx = sn;
                end else m_cnt++;
            end
        endcase
    endfunction

    function automatic logic [31:0] model_out();
        int st, ix;
        case (m_mode)
            M_HOME:  begin st = 0; ix = 0; end
            M_END:   begin st = 3; ix = N - 1; end
            M_FAULT: begin st = 6; ix = m_fidx; end
            default: begin
                case (m_k / N)
                    0: st = 1;
                    1: st = 2;
                    2: st = 4;
                    default: st = 5;
                endcase
                ix = sensor(m_k);
            end
        endcase
        return pack(st, ix, m_mode == M_RUN, m_dir, m_mode == M_FAULT, m_done);
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (!RSTn) model_reset();
        else model_step(IR, SW);
        @(negedge CLK);
    endtask

    task automatic drive(input logic [N-1:0] ir, input logic sw, input int n);
        IR = ir;
        SW = sw;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        IR = '1;
        SW = 1'b0;
        model_reset();
        repeat (2) tick();
        RSTn = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [N-1:0] ir;
        logic         sw;
        int           hold;
        int           st;
        int           ix;
        logic         e, d, f, dn;
        string        nm;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [N-1:0] ir, input logic sw, input int hold, input int st,
                                input int ix, input logic e, input logic d, input logic f,
                                input logic dn, input string nm);
        vec_t v;
        v.ir = ir; v.sw = sw; v.hold = hold; v.st = st; v.ix = ix;
        v.e = e; v.d = d; v.f = f; v.dn = dn; v.nm = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        model_reset();
        repeat (2) tick();
        check("reset_state", actual(), pack(0, 0, 0, 1, 0, 0));
        RSTn = 1'b1;
        tick();

        // Full forward + backward run; each input change lands S+1 edges later.
        add(3'b111, 1, 3, 1, 0, 1, 1, 0, 0, "start");
        add(3'b110, 0, 3, 1, 1, 1, 1, 0, 0, "fw_fall0");
        add(3'b100, 0, 3, 1, 2, 1, 1, 0, 0, "fw_fall1");
        add(3'b000, 0, 3, 2, 0, 1, 1, 0, 0, "fw_fall2");
        add(3'b001, 0, 3, 2, 1, 1, 1, 0, 0, "fw_rise0");
        add(3'b011, 0, 3, 2, 2, 1, 1, 0, 0, "fw_rise1");
        add(3'b111, 0, 3, 3, 2, 0, 1, 0, 0, "fw_rise2_end");
        add(3'b111, 0, 3, 3, 2, 0, 1, 0, 0, "dwell_3");
        add(3'b111, 0, 1, 4, 2, 1, 0, 0, 0, "dwell_4_reverse");
        add(3'b011, 0, 3, 4, 1, 1, 0, 0, 0, "bw_fall2");
        add(3'b001, 0, 3, 4, 0, 1, 0, 0, 0, "bw_fall1");
        add(3'b000, 0, 3, 5, 2, 1, 0, 0, 0, "bw_fall0");
        add(3'b100, 0, 3, 5, 1, 1, 0, 0, 0, "bw_rise2");
        add(3'b110, 0, 3, 5, 0, 1, 0, 0, 0, "bw_rise1");
        add(3'b111, 0, 3, 0, 0, 0, 1, 0, 1, "bw_rise0_done");
        add(3'b111, 0, 1, 0, 0, 0, 1, 0, 0, "done_clear");
        foreach (vecs[i]) begin
            drive(vecs[i].ir, vecs[i].sw, vecs[i].hold);
            check(vecs[i].nm, actual(), pack(vecs[i].st, vecs[i].ix, vecs[i].e, vecs[i].d,
                                              vecs[i].f, vecs[i].dn));
        end

        // Out-of-order sensor, three-edge latency, then SW clears the fault.
        do_reset();
        drive(3'b111, 1, 3);
        check("ooo_in_fw_fall", actual(), pack(1, 0, 1, 1, 0, 0));
        drive(3'b101, 0, 2);
        check("ooo_latency_2", actual(), pack(1, 0, 1, 1, 0, 0));
        tick();
        check("ooo_fault", actual(), pack(6, 0, 0, 1, 1, 0));
        drive(3'b101, 1, 3);
        check("ooo_clear", actual(), pack(0, 0, 0, 1, 0, 0));

        // Timeout exactly TO cycles after entering FW_FALL.
        do_reset();
        drive(3'b111, 1, 3);
        drive(3'b111, 0, TO - 1);
        check("timeout_minus1", actual(), pack(1, 0, 1, 1, 0, 0));
        tick();
        check("timeout_hit", actual(), pack(6, 0, 0, 1, 1, 0));

        // Expected and unexpected fall on the same edge.
        do_reset();
        drive(3'b111, 1, 3);
        drive(3'b010, 0, 3);
        check("simultaneous_fault", actual(), pack(6, 0, 0, 1, 1, 0));

        // Asynchronous reset in BW_FALL, then quiet after release.
        do_reset();
        drive(3'b111, 1, 3);
        drive(3'b110, 0, 3); drive(3'b100, 0, 3); drive(3'b000, 0, 3);
        drive(3'b001, 0, 3); drive(3'b011, 0, 3); drive(3'b111, 0, 3);
        drive(3'b111, 0, DW);
        drive(3'b011, 0, 3);
        check("bw_before_reset", actual(), pack(4, 1, 1, 0, 0, 0));
        #2 RSTn = 1'b0;
        #1 check("reset_async", actual(), pack(0, 0, 0, 1, 0, 0));
        @(negedge CLK);
        IR = '1;
        model_reset();
        RSTn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("post_reset_%0d", i), actual(), pack(0, 0, 0, 1, 0, 0));
        end

        // IR ignored in HOME; SW ignored in FW_RISE.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            IR = N'($urandom);
            tick();
            check($sformatf("home_ir_ignored_%0d", i), actual(), pack(0, 0, 0, 1, 0, 0));
        end
        drive(3'b111, 0, 4);
        drive(3'b111, 1, 3);
        drive(3'b110, 0, 3); drive(3'b100, 0, 3); drive(3'b000, 0, 3);
        drive(3'b000, 1, 3);
        check("sw_ignored_fw_rise", actual(), pack(2, 0, 1, 1, 0, 0));
        drive(3'b000, 0, 3);
        check("sw_release_fw_rise", actual(), pack(2, 0, 1, 1, 0, 0));

        // Randomized run against the reference model.
        do_reset();
        for (int a = 0; a < 600; a++) begin
            int r;
            int b;
            logic [N-1:0] t;
            r = $urandom_range(0, 99);
            t = IR;
            if (r < 2) begin
                RSTn = 1'b0;
                model_reset();
                #1 check($sformatf("rand_rst_%0d", a), actual(), model_out());
                tick();
                RSTn = 1'b1;
            end else if (m_mode == M_HOME || m_mode == M_FAULT) begin
                if (r < 60) begin
                    IR = '1;
                    SW = ~SW;
                end
            end else if (m_mode == M_RUN && r < 82) begin
                t[sensor(m_k)] = ((m_k / N) % 2 == 0) ? 1'b0 : 1'b1;
                IR = t;
            end else if (r < 92) begin
                b = $urandom_range(0, N - 1);
                t[b] = ~t[b];
                IR = t;
            end else if (r < 96) begin
                SW = ~SW;
            end
            repeat ($urandom_range(1, 4)) begin
                tick();
                check($sformatf("rand_%0d", a), actual(), model_out());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
